// File: rtl/ctrl_time_seq.sv
// Timed control source: steps a control value through a table of (time, value)
// segments on matches against the shared step counter. Modes: hold, cycle, toggle.
module ctrl_time_seq #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 12,
   parameter int unsigned IDX_W  = 2
) (
   input  logic                            clk,
   input  logic                            sta,
   input  logic [CNT_W-1:0]                counter,
   input  logic [1:0]                      mode,
   input  logic [IDX_W-1:0]                n_last,
   input  logic [(2**IDX_W)*CNT_W-1:0]     seg_time,
   input  logic [(2**IDX_W)*DATA_W-1:0]    seg_value,
   input  logic [DATA_W-1:0]               idle_value,
   output logic [DATA_W-1:0]               y,
   output logic [IDX_W-1:0]                idx,
   output logic                            evt,
   output logic                            done
);

   typedef enum logic [1:0] {LOAD, ARMED, RUN, DONE} state_t;

   localparam logic [1:0] MODE_CYCLE  = 2'd1;
   localparam logic [1:0] MODE_TOGGLE = 2'd2;

   state_t           state;
   logic [IDX_W-1:0] cur;
   logic [IDX_W-1:0] cur_nxt;
   logic [IDX_W-1:0] tgt_idx;
   logic [1:0]       mode_q;
   logic [IDX_W-1:0] n_last_q;
   logic [CNT_W-1:0] target;
   logic             match;
   logic             adv;
   logic             is_hold;

   // Target selection and match: counter one step ahead of the segment time.
   always_comb begin
      cur_nxt = IDX_W'(cur + 1'b1);
      is_hold = (mode_q != MODE_CYCLE) && (mode_q != MODE_TOGGLE);
      tgt_idx = '0;
      if (state == RUN && mode_q != MODE_TOGGLE &&
          !(mode_q == MODE_CYCLE && cur == n_last_q))
         tgt_idx = cur_nxt;
      target = seg_time[tgt_idx*CNT_W +: CNT_W];
      match  = (counter == CNT_W'(target - 1'b1));
   end

   // Sequencer: state, segment index and latched configuration.
   always_ff @(posedge clk or posedge sta) begin
      if (sta) begin
         state    <= LOAD;
         cur      <= '0;
         mode_q   <= '0;
         n_last_q <= '0;
         adv      <= 1'b0;
      end else begin
         adv <= 1'b0;
         case (state)
            LOAD: begin
               mode_q   <= mode;
               n_last_q <= n_last;
               state    <= ARMED;
            end
            ARMED: begin
               if (match) begin
                  adv   <= 1'b1;
                  cur   <= '0;
                  state <= (is_hold && n_last_q == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (match) begin
                  adv <= 1'b1;
                  if (mode_q == MODE_TOGGLE) begin
                     state <= ARMED;
                  end else if (mode_q == MODE_CYCLE) begin
                     cur <= (cur == n_last_q) ? '0 : cur_nxt;
                  end else begin
                     cur <= cur_nxt;
                     if (cur_nxt == n_last_q)
                        state <= DONE;
                  end
               end
            end
            DONE: begin
               cur <= cur;
            end
         endcase
      end
   end

   // Output stage: one cycle behind the sequencer, tracks live table values.
   always_ff @(posedge clk or posedge sta) begin
      if (sta) begin
         y    <= '0;
         idx  <= '0;
         evt  <= 1'b0;
         done <= 1'b0;
      end else begin
         y    <= (state == LOAD || state == ARMED) ? idle_value
                                                   : seg_value[cur*DATA_W +: DATA_W];
         idx  <= cur;
         evt  <= adv;
         done <= (state == DONE);
      end
   end

endmodule

// File: tb/tb_ctrl_time_seq.sv
// Directed bench for ctrl_time_seq: hold, cycle, toggle, wrap boundary and mid-run reset.
module tb_ctrl_time_seq;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CNT_W  = 12;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned N_SEG  = 4;

   localparam logic [63:0] VA = 64'hA000_0000_0000_00A1;
   localparam logic [63:0] VB = 64'hB000_0000_0000_00B2;
   localparam logic [63:0] VC = 64'hC000_0000_0000_00C3;
   localparam logic [63:0] VD = 64'hD000_0000_0000_00D4;
   localparam logic [63:0] VI = 64'h1111_2222_3333_4444;
   localparam logic [63:0] VV = 64'h5A5A_0000_1234_5678;

   logic                      clk = 1'b0;
   logic                      sta;
   logic [CNT_W-1:0]          counter;
   logic [1:0]                mode;
   logic [IDX_W-1:0]          n_last;
   logic [N_SEG*CNT_W-1:0]    seg_time;
   logic [N_SEG*DATA_W-1:0]   seg_value;
   logic [DATA_W-1:0]         idle_value;
   logic [DATA_W-1:0]         y;
   logic [IDX_W-1:0]          idx;
   logic                      evt;
   logic                      done;

   int n_chk   = 0;
   int n_fail  = 0;
   int evt_cnt = 0;

   always #5 clk = ~clk;

   ctrl_time_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .sta        (sta),
      .counter    (counter),
      .mode       (mode),
      .n_last     (n_last),
      .seg_time   (seg_time),
      .seg_value  (seg_value),
      .idle_value (idle_value),
      .y          (y),
      .idx        (idx),
      .evt        (evt),
      .done       (done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: counter advances just after the edge, outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
      counter = counter + 1'b1;
      if (evt) evt_cnt++;
   endtask

   task automatic go_to(input int c);
      for (int i = 0; i < 5000 && int'(counter) != c; i++) step();
      if (int'(counter) != c) check("go_to_bound", 64'(counter), 64'(c));
   endtask

   task automatic start(input logic [1:0] m, input logic [IDX_W-1:0] nl,
                        input logic [N_SEG*CNT_W-1:0] t, input logic [N_SEG*DATA_W-1:0] v,
                        input logic [DATA_W-1:0] idle, input logic [CNT_W-1:0] c0);
      @(posedge clk);
      #1;
      sta        = 1'b1;
      mode       = m;
      n_last     = nl;
      seg_time   = t;
      seg_value  = v;
      idle_value = idle;
      counter    = c0;
      evt_cnt    = 0;
      @(posedge clk);
      #1;
      sta = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sta        = 1'b1;
      counter    = '0;
      mode       = '0;
      n_last     = '0;
      seg_time   = '0;
      seg_value  = '0;
      idle_value = '0;
      #12;
      check("rst_y", y, 64'h0);
      check("rst_idx", 64'(idx), 64'h0);
      check("rst_evt", 64'(evt), 64'h0);
      check("rst_done", 64'(done), 64'h0);

      // HOLD, three segments; mode flipped mid-run must be ignored
      start(2'd0, 2'd2, {12'd0, 12'd30, 12'd20, 12'd10}, {VD, VC, VB, VA}, VI, 12'd0);
      check("h_load_y", y, 64'h0);
      step();
      check("h_idle_y", y, VI);
      go_to(10);  check("h_y10", y, VI);
      go_to(11);  check("h_y11", y, VA);  check("h_idx11", 64'(idx), 64'd0);
      mode = 2'd1;
      go_to(20);  check("h_y20", y, VA);
      go_to(21);  check("h_y21", y, VB);  check("h_idx21", 64'(idx), 64'd1);
      check("h_done21", 64'(done), 64'd0);
      go_to(30);  check("h_done30", 64'(done), 64'd0);
      go_to(31);  check("h_y31", y, VC);  check("h_idx31", 64'(idx), 64'd2);
      check("h_done31", 64'(done), 64'd1);
      go_to(4095); step();
      go_to(12);  check("h_y_wrap", y, VC);  check("h_done_wrap", 64'(done), 64'd1);
      check("h_evt_cnt", 64'(evt_cnt), 64'd3);

      // CYCLE, two segments, then reset while cur = 1
      start(2'd1, 2'd1, {12'd0, 12'd0, 12'd9, 12'd5}, {VD, VC, VB, VA}, VI, 12'd0);
      step();
      go_to(5);   check("c_y5", y, VI);
      go_to(6);   check("c_y6", y, VA);  check("c_idx6", 64'(idx), 64'd0);
      go_to(10);  check("c_y10", y, VB); check("c_idx10", 64'(idx), 64'd1);
      go_to(4095); step();
      go_to(5);   check("c_y5_p2", y, VB);
      go_to(6);   check("c_y6_p2", y, VA);
      go_to(10);  check("c_y10_p2", y, VB); check("c_done", 64'(done), 64'd0);
      check("c_evt_cnt", 64'(evt_cnt), 64'd4);
      sta = 1'b1;
      #1;
      check("mr_y", y, 64'h0);
      check("mr_idx", 64'(idx), 64'd0);
      check("mr_evt", 64'(evt), 64'd0);
      check("mr_done", 64'(done), 64'd0);
      #1;
      sta = 1'b0;
      check("mr_load_y", y, 64'h0);
      step();
      check("mr_idle_y", y, VI);

      // TOGGLE, legacy single-channel behaviour
      start(2'd2, 2'd3, {12'd0, 12'd0, 12'd0, 12'd100}, {VD, VC, VB, VV}, 64'h0, 12'd0);
      step();
      go_to(100); check("t_y100", y, 64'h0);
      go_to(101); check("t_y101", y, VV);
      go_to(4095); step();
      go_to(100); check("t_y100_p2", y, VV);
      go_to(101); check("t_y101_p2", y, 64'h0);
      check("t_idx", 64'(idx), 64'd0);
      check("t_done", 64'(done), 64'd0);
      check("t_evt_cnt", 64'(evt_cnt), 64'd2);

      // seg_time[0] = 0 matches at counter all ones
      start(2'd0, 2'd1, {12'd0, 12'd0, 12'd50, 12'd0}, {VD, VC, VB, VA}, VI, 12'd4000);
      step();
      go_to(4095); check("z_y4095", y, VI);
      step();      check("z_y0", y, VI);
      step();      check("z_y1", y, VA);
      go_to(51);   check("z_y51", y, VB); check("z_done51", 64'(done), 64'd1);

      // mode 3 behaves as HOLD; n_last = 0 finishes on the first match
      start(2'd3, 2'd0, {12'd0, 12'd0, 12'd0, 12'd40}, {VD, VC, VB, VA}, VI, 12'd0);
      step();
      go_to(40);  check("s_y40", y, VI);  check("s_done40", 64'(done), 64'd0);
      go_to(41);  check("s_y41", y, VA);  check("s_done41", 64'(done), 64'd1);
      check("s_idx41", 64'(idx), 64'd0);
      go_to(200); check("s_evt_cnt", 64'(evt_cnt), 64'd1);
      check("s_done200", 64'(done), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_time_seq.md
Name: ctrl_time_seq

Overview:
- Parametrised successor of the single-step timed control source.
- Drives a DATA_W-wide control value from a table of N_SEG (time, value) segments, stepping on matches against the shared step counter.
- Three modes: one-shot hold, cyclic repeat, and two-level toggle (the legacy behaviour).
- Sits between the solver step counter and the PV model input mux; one instance per controlled quantity.

Parameters:
- DATA_W, 64, width of control values (extended-single format, passed through untouched).
- CNT_W, 12, width of the step counter and segment times.
- IDX_W, 2, segment index width; N_SEG = 2**IDX_W.

Ports:
- clk  in  1  system clock.
- sta  in  1  asynchronous active-high reset/start.
- counter  in  CNT_W  shared step counter.
- mode  in  2  0 = HOLD, 1 = CYCLE, 2 = TOGGLE, 3 = treated as HOLD.
- n_last  in  IDX_W  index of the last active segment.
- seg_time  in  N_SEG*CNT_W  segment k time at bits [k*CNT_W +: CNT_W].
- seg_value  in  N_SEG*DATA_W  segment k value at bits [k*DATA_W +: DATA_W].
- idle_value  in  DATA_W  value driven before the first event.
- y  out  DATA_W  registered control output.
- idx  out  IDX_W  segment currently on y, registered and aligned with y.
- evt  out  1  one-cycle pulse, aligned with every y change.
- done  out  1  high while in DONE.

Behaviour:
- States: LOAD, ARMED, RUN, DONE.
- Reset (sta high, async): state = LOAD, cur = 0, y = 0, idx = 0, evt = 0, done = 0.
- LOAD: lasts exactly one clk after sta falls. Latches mode and n_last into internal registers; later changes to these inputs are ignored until the next sta. Then goes to ARMED.
- Match definition: counter == target - 1, computed modulo 2^CNT_W. A target of 0 therefore matches counter = all ones.
  - seg_time and seg_value are read live, not latched.
  - At most one advance per clk.
- ARMED: target = seg_time[0]. On match: go to RUN, cur = 0.
- RUN with HOLD: target = seg_time[cur+1].
  - On match, cur increments.
  - When cur == n_last_latched, no target remains; go to DONE on the same edge cur reaches n_last.
  - If n_last = 0: ARMED match goes straight to DONE with cur = 0.
- RUN with CYCLE: target = seg_time[cur+1], or seg_time[0] when cur == n_last. On that final match cur wraps to 0. Never enters DONE.
- RUN with TOGGLE: target = seg_time[0]; n_last is ignored. On match return to ARMED. Result: y alternates idle_value / seg_value[0] on every match.
- DONE: holds cur; ignores counter; done = 1.
- Output stage (second register stage):
  - y = idle_value in LOAD/ARMED, else seg_value[cur].
  - idx = cur.
  - evt = 1 on the edge where y is loaded as a result of a state/cur change in the preceding stage.
- Latency:
  - Edge 1 samples the match and updates state/cur.
  - Edge 2 updates y, idx and evt.
  - If counter increments every clk, the new y is first visible while counter == target + 1.
- y also tracks live seg_value/idle_value changes with 1-cycle latency. No evt is generated for these.
- Reset mid-operation: immediate return to reset values regardless of state. Same-cycle match is discarded.
- Counter wrap: no special handling. Segments scheduled past wrap simply match on the next counter pass.

Test Plan:
- HOLD, n_last = 2, times {10, 20, 30}, values {A, B, C}, idle = I, counter 0..4095 per clk.
  - Required y: 0 during LOAD, I until counter = 11, A from counter 11, B from 21, C from 31.
  - done rises with the C update.
  - evt pulses exactly 3 times; idx = 0, 1, 2.
- CYCLE, n_last = 1, times {5, 9}.
  - Required y sequence: I → A at counter 6 → B at 10 → A at 6 of the next counter pass, and so on.
  - done stays 0.
- TOGGLE, time 100, value V, idle 0.
  - Required y: 0 → V at counter 101 → 0 at counter 101 of the next pass, and so on.
  - Reproduces legacy single-channel behaviour.
- Boundary case: seg_time[0] = 0 → match at counter 4095; y = A when counter shows 1.
- Boundary case: HOLD with n_last = 0 → single evt, done asserted together with y = A.
- Reset mid-RUN (cur = 1): assert sta → y, idx, evt, done go to 0 asynchronously.
  - After release, one LOAD cycle, then y = I.
- Latch check: change mode from 0 to 1 during RUN → behaviour unchanged until the next sta.
